reorder_buffer: RTL and testbench

Parametrised reorder buffer that sits between rename/dispatch and the free pool, closing the currently open `rob_push` / `rob_free_reg` path. It allocates one entry per dispatched instruction in program order and accepts out-of-order completion on `CPL_PORTS` writeback channels. It retires up to `RETIRE_W` consecutive completed entries per cycle and returns each retiring instruction's old physical destination to the free pool. It supersedes the single-port, single-retire push/free-reg handshake; `flush` adds a whole-buffer clear.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/rob_retire_sel.sv | 23 ++
 rtl/reorder_buffer.sv | 112 +++++++++++
 tb/tb_reorder_buffer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: widths, register-zero constant and ROB entry layout shared across the core
package cpu_pkg;
  localparam int DEF_PREG_WIDTH = 6;
  localparam int DEF_AREG_WIDTH = 5;
  localparam int DEF_PC_WIDTH = 12;
  localparam logic [DEF_PREG_WIDTH-1:0] PREG_ZERO = '0;
  typedef struct packed {
    logic valid;
    logic done;
    logic reg_write;
    logic [DEF_AREG_WIDTH-1:0] rd;
    logic [DEF_PREG_WIDTH-1:0] prd;
    logic [DEF_PREG_WIDTH-1:0] old_prd;
    logic [DEF_PC_WIDTH-1:0] pc;
  } rob_entry_t;
endpackage

// File: rtl/rob_retire_sel.sv
// rob_retire_sel: contiguous retire mask from head plus its popcount
module rob_retire_sel #(
  parameter int W = 2
) (
  input  logic [W-1:0]           valid,
  input  logic [W-1:0]           done,
  output logic [W-1:0]           mask,
  output logic [$clog2(W+1)-1:0] cnt
);
  localparam int CW = $clog2(W + 1);
  // a slot retires only while every older slot also retires
  always_comb begin
    logic run;
    run = 1'b1;
    mask = '0;
    cnt = '0;
    for (int j = 0; j < W; j++) begin
      run = run && valid[j] && done[j];
      mask[j] = run;
      cnt = cnt + CW'(run);
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement of out-of-order completions, returning old physical registers
module reorder_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PREG_WIDTH = DEF_PREG_WIDTH,
  parameter int AREG_WIDTH = DEF_AREG_WIDTH,
  parameter int PC_WIDTH = DEF_PC_WIDTH,
  parameter int CPL_PORTS = 2,
  parameter int RETIRE_W = 2,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alloc_valid,
  output logic                           alloc_ready,
  input  logic                           alloc_reg_write,
  input  logic [AREG_WIDTH-1:0]          alloc_rd,
  input  logic [PREG_WIDTH-1:0]          alloc_prd,
  input  logic [PREG_WIDTH-1:0]          alloc_old_prd,
  input  logic [PC_WIDTH-1:0]            alloc_pc,
  output logic [IDXW-1:0]                alloc_tag,
  input  logic [CPL_PORTS-1:0]           cpl_valid,
  input  logic [CPL_PORTS*IDXW-1:0]      cpl_tag,
  input  logic                           flush,
  output logic [RETIRE_W-1:0]            ret_valid,
  output logic [RETIRE_W*AREG_WIDTH-1:0] ret_rd,
  output logic [RETIRE_W*PREG_WIDTH-1:0] ret_prd,
  output logic [RETIRE_W*PC_WIDTH-1:0]   ret_pc,
  output logic [RETIRE_W-1:0]            free_push,
  output logic [RETIRE_W*PREG_WIDTH-1:0] free_reg,
  output logic [IDXW:0]                  count,
  output logic                           empty,
  output logic                           full
);
  localparam int CW = $clog2(RETIRE_W + 1);
  rob_entry_t ent_q [DEPTH];
  rob_entry_t ent_d [DEPTH];
  logic [IDXW:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [RETIRE_W-1:0] sel_v, sel_d, mask;
  logic [CW-1:0] sel_n, n_ret;
  logic alloc_fire;
  assign full = (head_q[IDXW-1:0] == tail_q[IDXW-1:0]) && (head_q[IDXW] != tail_q[IDXW]);
  assign empty = head_q == tail_q;
  assign alloc_ready = !full && !flush;
  assign alloc_tag = tail_q[IDXW-1:0];
  assign count = count_q;
  assign alloc_fire = alloc_valid && alloc_ready;
  assign ret_valid = flush ? '0 : mask;
  assign n_ret = flush ? '0 : sel_n;
  for (genvar i = 0; i < RETIRE_W; i++) begin : g_slot
    logic [IDXW-1:0] idx;
    assign idx = head_q[IDXW-1:0] + IDXW'(i);
    assign sel_v[i] = ent_q[idx].valid;
    assign sel_d[i] = ent_q[idx].done;
    assign ret_rd[i*AREG_WIDTH +: AREG_WIDTH] = ent_q[idx].rd;
    assign ret_prd[i*PREG_WIDTH +: PREG_WIDTH] = ent_q[idx].prd;
    assign ret_pc[i*PC_WIDTH +: PC_WIDTH] = ent_q[idx].pc;
    assign free_reg[i*PREG_WIDTH +: PREG_WIDTH] = ent_q[idx].old_prd;
    assign free_push[i] = ret_valid[i] && ent_q[idx].reg_write && ent_q[idx].old_prd != PREG_ZERO;
  end
  rob_retire_sel #(.W(RETIRE_W)) u_sel (
    .valid(sel_v),
    .done (sel_d),
    .mask (mask),
    .cnt  (sel_n)
  );
  // completion marks done, retirement frees slots, allocation fills tail; flush drops all three
  always_comb begin
    logic [IDXW-1:0] idx;
    ent_d = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    idx = '0;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      head_d = '0;
      tail_d = '0;
      count_d = '0;
    end else begin
      for (int k = 0; k < CPL_PORTS; k++) begin
        idx = cpl_tag[k*IDXW +: IDXW];
        if (cpl_valid[k] && ent_q[idx].valid) ent_d[idx].done = 1'b1;
      end
      for (int j = 0; j < RETIRE_W; j++) begin
        idx = head_q[IDXW-1:0] + IDXW'(j);
        if (ret_valid[j]) ent_d[idx].valid = 1'b0;
      end
      if (alloc_fire)
        ent_d[tail_q[IDXW-1:0]] = '{valid: 1'b1, done: 1'b0, reg_write: alloc_reg_write, rd: alloc_rd,
                                    prd: alloc_prd, old_prd: alloc_old_prd, pc: alloc_pc};
      head_d = head_q + (IDXW+1)'(n_ret);
      tail_d = tail_q + (IDXW+1)'(alloc_fire);
      count_d = count_q + (IDXW+1)'(alloc_fire) - (IDXW+1)'(n_ret);
    end
  end
  // state registers; reset clears every field so idle outputs read zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      ent_q <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: randomized and directed checks against a program-order queue model
module tb_reorder_buffer;
  localparam int DEPTH = 16, PW = 6, AW = 5, PCW = 12, CP = 2, RW = 2, IW = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic alloc_valid = 1'b0, alloc_ready, alloc_reg_write = 1'b0;
  logic [AW-1:0] alloc_rd = '0;
  logic [PW-1:0] alloc_prd = '0, alloc_old_prd = '0;
  logic [PCW-1:0] alloc_pc = '0;
  logic [IW-1:0] alloc_tag;
  logic [CP-1:0] cpl_valid = '0;
  logic [CP*IW-1:0] cpl_tag = '0;
  logic flush = 1'b0;
  logic [RW-1:0] ret_valid, free_push;
  logic [RW*AW-1:0] ret_rd;
  logic [RW*PW-1:0] ret_prd, free_reg;
  logic [RW*PCW-1:0] ret_pc;
  logic [IW:0] count;
  logic empty, full;
  reorder_buffer #(.DEPTH(DEPTH), .PREG_WIDTH(PW), .AREG_WIDTH(AW), .PC_WIDTH(PCW),
                   .CPL_PORTS(CP), .RETIRE_W(RW)) dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_reg_write(alloc_reg_write), .alloc_rd(alloc_rd), .alloc_prd(alloc_prd),
    .alloc_old_prd(alloc_old_prd), .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .flush(flush), .ret_valid(ret_valid),
    .ret_rd(ret_rd), .ret_prd(ret_prd), .ret_pc(ret_pc), .free_push(free_push),
    .free_reg(free_reg), .count(count), .empty(empty), .full(full)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  typedef struct {int tag; int rw; int rd; int prd; int old; int pc; bit done;} ent_t;
  ent_t q[$];
  int next_tag = 0;
  task automatic step(input bit av, input bit rw, input int old, input bit [1:0] cv,
                      input int t0, input int t1, input bit fl);
    logic [RW-1:0] erv, efp;
    bit go, acc;
    int n;
    ent_t e;
    @(negedge clk);
    e = '{tag: next_tag, rw: int'(rw), rd: $urandom_range(0, 31), prd: $urandom_range(0, 63),
          old: old, pc: $urandom_range(0, 4095), done: 1'b0};
    alloc_valid = av;
    alloc_reg_write = rw;
    alloc_rd = AW'(e.rd);
    alloc_prd = PW'(e.prd);
    alloc_old_prd = PW'(e.old);
    alloc_pc = PCW'(e.pc);
    cpl_valid = cv;
    cpl_tag = {IW'(t1), IW'(t0)};
    flush = fl;
    #1;
    erv = '0;
    efp = '0;
    go = !fl;
    n = 0;
    for (int j = 0; j < RW; j++) begin
      if (j >= q.size()) go = 1'b0;
      else go = go && q[j].done;
      erv[j] = go;
      if (go) begin
        n++;
        efp[j] = q[j].rw != 0 && q[j].old != 0;
        check("ret_rd", ret_rd[j*AW +: AW], q[j].rd);
        check("ret_prd", ret_prd[j*PW +: PW], q[j].prd);
        check("ret_pc", ret_pc[j*PCW +: PCW], q[j].pc);
        check("free_reg", free_reg[j*PW +: PW], q[j].old);
      end
    end
    check("ret_valid", ret_valid, erv);
    check("free_push", free_push, efp);
    check("count", count, q.size());
    check("empty", empty, q.size() == 0);
    check("full", full, q.size() == DEPTH);
    check("alloc_ready", alloc_ready, !fl && q.size() < DEPTH);
    check("alloc_tag", alloc_tag, next_tag);
    if (fl) begin
      q.delete();
      next_tag = 0;
    end else begin
      acc = av && q.size() < DEPTH;
      repeat (n) void'(q.pop_front());
      for (int k = 0; k < CP; k++)
        if (cv[k])
          foreach (q[i]) if (q[i].tag == ((k == 0 ? t0 : t1) % DEPTH)) q[i].done = 1'b1;
      if (acc) begin
        q.push_back(e);
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
  endtask
  task automatic idle();
    step(0, 0, 0, 2'b00, 0, 0, 0);
  endtask
  initial begin
    int t0, t1, pa;
    repeat (3) @(negedge clk);
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, 0);
    check("rst_ret_valid", ret_valid, 0);
    rst = 1'b1;
    idle();
    check("rel_alloc_ready", alloc_ready, 1'b1);
    for (int i = 0; i < 4; i++) step(1, 1, 5 + i, 2'b00, 0, 0, 0);
    step(0, 0, 0, 2'b01, 3, 0, 0);
    step(0, 0, 0, 2'b01, 1, 0, 0);
    step(0, 0, 0, 2'b01, 2, 0, 0);
    step(0, 0, 0, 2'b01, 0, 0, 0);
    idle();
    check("ooo_rv01", ret_valid, 2'b11);
    check("ooo_free01", free_reg, {6'd6, 6'd5});
    idle();
    check("ooo_rv23", ret_valid, 2'b11);
    check("ooo_free23", free_reg, {6'd8, 6'd7});
    step(0, 0, 0, 2'b00, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 1, 9, 2'b00, 0, 0, 0);
    step(1, 1, 9, 2'b01, 0, 0, 0);
    check("fill_full", full, 1'b1);
    check("fill_ready", alloc_ready, 1'b0);
    check("fill_tag", alloc_tag, 0);
    step(1, 1, 9, 2'b00, 0, 0, 0);
    check("simul_ret", ret_valid[0], 1'b1);
    check("simul_refuse", alloc_ready, 1'b0);
    step(1, 1, 9, 2'b00, 0, 0, 0);
    check("simul_accept", alloc_ready, 1'b1);
    idle();
    check("simul_count", count, DEPTH);
    step(0, 0, 0, 2'b00, 0, 0, 1);
    step(1, 0, 4, 2'b00, 0, 0, 0);
    step(1, 1, 0, 2'b00, 0, 0, 0);
    step(0, 0, 0, 2'b11, 0, 1, 0);
    idle();
    check("filt_rv", ret_valid, 2'b11);
    check("filt_push", free_push, 2'b00);
    step(0, 0, 0, 2'b00, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 3, 2'b00, 0, 0, 0);
    step(0, 0, 0, 2'b11, 2, 3, 0);
    step(0, 0, 0, 2'b00, 0, 0, 1);
    check("flush_noret", ret_valid, 0);
    idle();
    check("flush_count", count, 0);
    check("flush_tag", alloc_tag, 0);
    step(0, 0, 0, 2'b01, 2, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 3, 2'b00, 0, 0, 0);
    step(0, 0, 0, 2'b11, 0, 1, 0);
    idle();
    check("stale_rv", ret_valid, 2'b11);
    idle();
    check("stale_ignored", ret_valid, 2'b00);
    for (int i = 0; i < 3000; i++) begin
      pa = (i / 300) % 3 == 0 ? 90 : ((i / 300) % 3 == 1 ? 50 : 20);
      t0 = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, q.size() - 1)].tag : $urandom_range(0, 15);
      t1 = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, q.size() - 1)].tag : $urandom_range(0, 15);
      step($urandom_range(0, 99) < pa, 1'($urandom), $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 63),
           2'($urandom), t0, t1, $urandom_range(0, 63) == 0);
      if (i == 1500) begin
        #2;
        rst = 1'b0;
        #1;
        check("arst_empty", empty, 1'b1);
        check("arst_count", count, 0);
        check("arst_ret_valid", ret_valid, 0);
        q.delete();
        next_tag = 0;
        @(negedge clk);
        alloc_valid = 1'b0;
        cpl_valid = '0;
        flush = 1'b0;
        rst = 1'b1;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
